// File: rtl/sdb_word_seq.sv
// sdb_word_seq - multi-precision add sequencer around one external WIDTH-bit
// sdb_inner slice. A WIDTH*WORDS-bit operand set is accepted over a
// valid/ready handshake. The sequencer feeds the slice one word per cycle,
// least significant word first, and carries the slice carry between words
// in a register. It then presents the assembled sum and the final carry over
// a second valid/ready handshake. The sequencer does no arithmetic of its
// own: every sum bit comes from the slice.
//
// State table
//   state  | meaning
//   IDLE   | waiting for an operand set (in_ready=1)
//   RUN    | word idx is at the slice; sum word and carry are captured each cycle
//   DONE   | result presented (out_valid=1) until out_ready
//
// Ports
//   clk, rst_n                     clock; synchronous active-low reset
//   in_valid/in_ready              operand handshake
//   in_a/in_b/in_p/in_c_in         operand set and the carry into word 0
//   slc_a/slc_b/slc_p/slc_c_in     current word to the slice (0 outside RUN)
//   slc_s/slc_c_out                combinational slice result
//   out_valid/out_ready            result handshake
//   out_s/out_c_out                assembled sum and carry out of the top word
//   busy                           high in RUN or DONE
module sdb_word_seq #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic [WIDTH*WORDS-1:0] in_p,
    input  logic                   in_c_in,
    output logic [WIDTH-1:0]       slc_a,
    output logic [WIDTH-1:0]       slc_b,
    output logic [WIDTH-1:0]       slc_p,
    output logic                   slc_c_in,
    input  logic [WIDTH-1:0]       slc_s,
    input  logic                   slc_c_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_s,
    output logic                   out_c_out,
    output logic                   busy
);

    localparam int TW = WIDTH * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [TW-1:0]   a_q;
    logic [TW-1:0]   b_q;
    logic [TW-1:0]   p_q;
    logic [TW-1:0]   res_q;
    logic [TW-1:0]   res_d;

    logic            run;
    logic [31:0]     shamt;
    logic [TW-1:0]   a_sh;
    logic [TW-1:0]   b_sh;
    logic [TW-1:0]   p_sh;

    // Word select by shifting the captured operand down; the low WIDTH bits
    // are the word at idx.
    assign shamt = 32'(idx_q) * 32'(WIDTH);
    assign a_sh  = a_q >> shamt;
    assign b_sh  = b_q >> shamt;
    assign p_sh  = p_q >> shamt;

    // All outputs are forced to zero while reset is asserted, even during the
    // cycle before the reset edge takes effect.
    assign run       = rst_n && (state_q == S_RUN);
    assign slc_a     = run ? a_sh[WIDTH-1:0] : '0;
    assign slc_b     = run ? b_sh[WIDTH-1:0] : '0;
    assign slc_p     = run ? p_sh[WIDTH-1:0] : '0;
    assign slc_c_in  = run && carry_q;

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = rst_n && (state_q == S_DONE);
    assign busy      = rst_n && ((state_q == S_RUN) || (state_q == S_DONE));
    assign out_s     = rst_n ? res_q : '0;
    assign out_c_out = rst_n && carry_q;

    // Insert the slice sum into result word idx.
    always_comb begin
        res_d = res_q;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) begin
                res_d[w*WIDTH +: WIDTH] = slc_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        p_q     <= in_p;
                        carry_q <= in_c_in;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= slc_c_out;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result registers hold after the handshake; only
                    // out_valid drops.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdb_word_seq.sv
module tb_sdb_word_seq;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int TW    = WIDTH * WORDS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [TW-1:0]   in_a, in_b, in_p;
    logic            in_c_in;
    logic [WIDTH-1:0] slc_a, slc_b, slc_p, slc_s;
    logic            slc_c_in, slc_c_out;
    logic            out_valid, out_ready;
    logic [TW-1:0]   out_s;
    logic            out_c_out;
    logic            busy;

    always #5 clk = ~clk;

    sdb_word_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_p      (in_p),
        .in_c_in   (in_c_in),
        .slc_a     (slc_a),
        .slc_b     (slc_b),
        .slc_p     (slc_p),
        .slc_c_in  (slc_c_in),
        .slc_s     (slc_s),
        .slc_c_out (slc_c_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c_out (out_c_out),
        .busy      (busy)
    );

    // Slice model: plain adder, p ignored.
    assign {slc_c_out, slc_s} = {1'b0, slc_a} + {1'b0, slc_b} + {{WIDTH{1'b0}}, slc_c_in};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic [TW-1:0] p;
        logic          cin;
        logic [TW-1:0] s;
        logic          cout;
        int            acc;
    } txn_t;

    function automatic logic [WIDTH-1:0] word_of(input logic [TW-1:0] x, input int k);
        logic [TW-1:0] t;
        t = x >> (k * WIDTH);
        return t[WIDTH-1:0];
    endfunction

    // Carry entering word k of a+b+cin, from the sum of the lower k words.
    function automatic logic carry_into(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                        input logic cin, input int k);
        logic [63:0] mask, t;
        if (k == 0) return cin;
        mask = (64'd1 << (k * WIDTH)) - 64'd1;
        t = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
        return t[k*WIDTH];
    endfunction

    txn_t          exp_q[$];
    int            acc_hist[$];
    int            neg_cnt = 0;
    int            acc_cnt = 0;
    int            pop_cnt = 0;
    int            run_k   = 0;
    logic          prev_ov = 1'b0;
    logic          hold    = 1'b0;
    logic [TW-1:0] held_s;
    logic          held_c;
    logic [TW-1:0] last_s;
    logic          last_c;
    logic          rr_mode = 1'b0;

    always @(negedge clk) begin
        txn_t h, n;
        logic [TW:0] full;
        neg_cnt++;
        if (!rst_n) begin
            check("rst_ctrl", 64'({in_ready, out_valid, busy, out_c_out, slc_c_in}), 64'd0);
            check("rst_out_s", 64'(out_s), 64'd0);
            check("rst_slc", 64'({slc_a, slc_b, slc_p}), 64'd0);
            exp_q.delete();
            run_k   = 0;
            hold    = 1'b0;
            prev_ov = 1'b0;
        end else begin
            check("ready_vs_busy", 64'(in_ready), 64'(!busy));
            if (busy && !out_valid) begin
                if (exp_q.size() == 0) begin
                    check("run_without_txn", 64'(exp_q.size()), 64'd1);
                end else begin
                    h = exp_q[0];
                    check("slc_a", 64'(slc_a), 64'(word_of(h.a, run_k)));
                    check("slc_b", 64'(slc_b), 64'(word_of(h.b, run_k)));
                    check("slc_p", 64'(slc_p), 64'(word_of(h.p, run_k)));
                    check("slc_c_in", 64'(slc_c_in), 64'(carry_into(h.a, h.b, h.cin, run_k)));
                    run_k++;
                end
            end else begin
                check("slc_zero", 64'({slc_a, slc_b, slc_p, slc_c_in}), 64'd0);
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 64'(exp_q.size()), 64'd1);
                    end else begin
                        check("latency", 64'(neg_cnt - exp_q[0].acc), 64'(WORDS + 1));
                        check("run_len", 64'(run_k), 64'(WORDS));
                    end
                end
                if (hold) begin
                    check("stable_s", 64'(out_s), 64'(held_s));
                    check("stable_c", 64'(out_c_out), 64'(held_c));
                end
                if (out_ready && exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    check("out_s", 64'(out_s), 64'(h.s));
                    check("out_c_out", 64'(out_c_out), 64'(h.cout));
                    last_s = out_s;
                    last_c = out_c_out;
                    pop_cnt++;
                end
                hold   = !out_ready;
                held_s = out_s;
                held_c = out_c_out;
            end else begin
                if (hold) check("valid_dropped", 64'(out_valid), 64'd1);
                hold = 1'b0;
            end
            prev_ov = out_valid;
            if (in_valid && in_ready) begin
                full   = {1'b0, in_a} + {1'b0, in_b} + {{TW{1'b0}}, in_c_in};
                n.a    = in_a;
                n.b    = in_b;
                n.p    = in_p;
                n.cin  = in_c_in;
                n.s    = full[TW-1:0];
                n.cout = full[TW];
                n.acc  = neg_cnt;
                exp_q.push_back(n);
                acc_hist.push_back(neg_cnt);
                acc_cnt++;
                run_k = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (rr_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic [TW-1:0] p, input logic cin, input bit keep);
        int start, t;
        in_a     = a;
        in_b     = b;
        in_p     = p;
        in_c_in  = cin;
        in_valid = 1'b1;
        start    = acc_cnt;
        t        = 0;
        while (acc_cnt == start && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (acc_cnt == start) check("accept_timeout", 64'(acc_cnt - start), 64'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int t, start, n_rand;
        logic [TW:0] r;
        logic [TW-1:0] a2, b2;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_p = '0; in_c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_s", 64'(out_s), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // basic carry chain
        out_ready = 1'b1;
        send(32'h000000FF, 32'h00000001, TW'($urandom), 1'b0, 1'b0);
        wait_idle();
        check("basic_s", 64'(last_s), 64'h00000100);
        check("basic_c", 64'(last_c), 64'd0);

        // full ripple with carry-in
        send(32'hFFFFFFFF, 32'h00000000, TW'($urandom), 1'b1, 1'b0);
        wait_idle();
        check("ripple_s", 64'(last_s), 64'h00000000);
        check("ripple_c", 64'(last_c), 64'd1);

        // backpressure
        out_ready = 1'b0;
        send(32'h12345678, 32'h11111111, TW'($urandom), 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("bp_s", 64'(out_s), 64'h23456789);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        check("bp_last_s", 64'(last_s), 64'h23456789);

        // back-to-back with in_valid held high
        a2 = TW'($urandom); b2 = TW'($urandom);
        start = acc_hist.size();
        send(TW'($urandom), TW'($urandom), TW'($urandom), 1'b0, 1'b1);
        send(a2, b2, TW'($urandom), 1'b1, 1'b0);
        wait_idle();
        if (acc_hist.size() >= start + 2)
            check("b2b_interval", 64'(acc_hist[start+1] - acc_hist[start]), 64'(WORDS + 2));
        else
            check("b2b_accepts", 64'(acc_hist.size() - start), 64'd2);
        r = {1'b0, a2} + {1'b0, b2} + {{TW{1'b0}}, 1'b1};
        check("b2b_second_s", 64'(last_s), 64'(r[TW-1:0]));

        // reset in RUN cycle 2
        start = pop_cnt;
        send(TW'($urandom), TW'($urandom), TW'($urandom), 1'b1, 1'b0);
        @(posedge clk); #1;
        check("abort_in_run", 64'({busy, out_valid}), 64'b10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_slc", 64'({slc_a, slc_b, slc_p, slc_c_in}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", 64'(pop_cnt - start), 64'd0);
        send(32'h1, 32'h1, TW'($urandom), 1'b0, 1'b0);
        wait_idle();
        check("after_abort_s", 64'(last_s), 64'h00000002);

        // randomized traffic with random backpressure
        start  = pop_cnt;
        n_rand = 25;
        rr_mode = 1'b1;
        for (int i = 0; i < n_rand; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(TW'($urandom), TW'($urandom), TW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        wait_idle();
        rr_mode = 1'b0;
        check("rand_count", 64'(pop_cnt - start), 64'(n_rand));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdb_word_seq.md
Name: sdb_word_seq

Overview:
- Multi-precision add sequencer for one external sdb_inner slice of WIDTH bits.
- Accepts a WIDTH*WORDS-bit operand set (a, b, p, c_in) over a valid/ready handshake.
- Presents the operands to the slice one WIDTH-bit word per cycle, LSW first, and chains the slice carry between words through a register.
- Collects the sum words and returns the full result with the final carry over a second valid/ready handshake.
- Lets wide additions reuse a single narrow slice.

Parameters:
- WIDTH, 8: slice width; even, >2; must match the attached sdb_inner.
- WORDS, 4: words per operand, >=1; the sequence takes WORDS slice cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept an operand set.
- in_a  in  WIDTH*WORDS  operand a.
- in_b  in  WIDTH*WORDS  operand b.
- in_p  in  WIDTH*WORDS  per-bit p vector for the slice.
- in_c_in  in  1  carry into word 0.
- slc_a  out  WIDTH  word of a to the slice.
- slc_b  out  WIDTH  word of b to the slice.
- slc_p  out  WIDTH  word of p to the slice.
- slc_c_in  out  1  carry into the slice.
- slc_s  in  WIDTH  slice sum, combinational from slc_* in the same cycle.
- slc_c_out  in  1  slice carry out, combinational.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_s  out  WIDTH*WORDS  assembled sum.
- out_c_out  out  1  carry out of word WORDS-1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clocking and reset:
  - One clock, clk. rst_n is synchronous, active-low, sampled on the rising edge.
  - Reset state: IDLE; index counter=0; carry_reg=0; operand and result registers=0.
  - Output values with rst_n low: in_ready=0, out_valid=0, out_s=0, out_c_out=0, busy=0, slc_*=0.
- State IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid&&in_ready: capture in_a/in_b/in_p, carry_reg<=in_c_in, idx<=0, go to RUN.
- State RUN:
  - in_ready=0, busy=1.
  - slc_a/b/p = captured word idx (bits idx*WIDTH+WIDTH-1 : idx*WIDTH); slc_c_in = carry_reg.
  - Each cycle: result word idx<=slc_s, carry_reg<=slc_c_out.
  - If idx==WORDS-1, go to DONE; else idx<=idx+1.
  - Index counter width is max(1, clog2(WORDS)). idx never exceeds WORDS-1 and does not wrap inside a sequence.
- State DONE:
  - out_valid=1; out_s = result register; out_c_out = carry_reg.
  - slc_* = 0; in_ready=0; busy=1.
  - On out_ready: go to IDLE. Result registers hold their value, but out_valid=0 in IDLE.
- Latency:
  - Accept edge = cycle 0. RUN occupies cycles 1..WORDS. out_valid rises in cycle WORDS+1.
  - Minimum issue interval WORDS+2 cycles: accept, WORDS RUN cycles, and DONE with out_ready=1 in its first cycle. The next accept happens in the following IDLE cycle.
- Slice outputs outside RUN: slc_a/b/p/c_in=0.
- Handshake rules:
  - out_s and out_c_out are stable while out_valid=1 and out_ready=0.
  - in_valid is ignored outside IDLE; the upstream holds its data.
- Edge cases:
  - WORDS=1: a single RUN cycle, then DONE.
  - rst_n low in RUN or DONE: abort to IDLE next edge. The partial result is discarded and no out_valid is issued.
  - in_valid and out_ready both high in DONE: only the out handshake completes. The input is accepted in the following IDLE cycle.
- Arithmetic: the sequencer performs no arithmetic. Sum bits come only from slc_s; carry propagates only through carry_reg.

Test Plan:
- Test bench setup: the slice is modelled as s = a+b+c_in (p ignored), WIDTH=8, WORDS=4.
- Basic carry chain: in_a=0x000000FF, in_b=0x00000001, in_c_in=0, out_ready=1 -> out_s=0x00000100, out_c_out=0; out_valid rises exactly 5 cycles after the accept edge.
- Full ripple with carry-in: in_a=0xFFFFFFFF, in_b=0x00000000, in_c_in=1 -> out_s=0x00000000, out_c_out=1. The slc_c_in trace over RUN cycles is 1,1,1,1.
- Backpressure: in_a=0x12345678, in_b=0x11111111, out_ready held low 6 cycles in DONE -> out_s=0x23456789 stable; in_ready=0 and busy=1 throughout; IDLE one cycle after out_ready rises.
- Back-to-back: two operand sets with in_valid held high and out_ready=1 -> second accept exactly 6 cycles after the first; results correct and in order.
- Reset mid-run: rst_n low in RUN cycle 2 -> next edge in IDLE with out_valid=0 and slc_*=0. No result is ever presented. A following add of 0x1+0x1 returns 0x00000002.
